// File: rtl/write_pointer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : write_pointer_ctrl
// Description : Write-side pointer controller for a synchronous FIFO. Gates
//               write requests against full, advances the write pointer,
//               derives occupancy / full / almost-full against the read
//               pointer and records rejected (overflow) writes.
// Revision    : 1.0 - initial release
// ============================================================================
module write_pointer_ctrl #(
    parameter int ADDR_WIDTH     = 3,
    parameter int AF_THRESH      = 6,
    parameter int DROP_CNT_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      i_wr,
    input  logic [ADDR_WIDTH:0]       rptr,
    input  logic                      ovf_clr,
    output logic                      fifo_wr,
    output logic [ADDR_WIDTH:0]       wptr,
    output logic                      fifo_full,
    output logic                      fifo_almost_full,
    output logic [ADDR_WIDTH:0]       fifo_count,
    output logic                      wr_ack,
    output logic                      overflow,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);

    localparam int                        c_PTR_W    = ADDR_WIDTH + 1;
    localparam logic [c_PTR_W-1:0]        c_AF       = c_PTR_W'(AF_THRESH);
    localparam logic [c_PTR_W-1:0]        c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [DROP_CNT_WIDTH-1:0] c_DROP_MAX = '1;
    localparam logic [DROP_CNT_WIDTH-1:0] c_DROP_ONE = DROP_CNT_WIDTH'(1);

    logic [c_PTR_W-1:0]        r_wptr;
    logic                      r_wr_ack;
    logic                      r_overflow;
    logic [DROP_CNT_WIDTH-1:0] r_drop_cnt;

    logic                      w_full;
    logic                      w_accept;
    logic                      w_reject;
    logic [c_PTR_W-1:0]        w_count;

    // Flags and occupancy from the current pointers; the wrap bit
    // distinguishes full from empty when the address bits match.
    always_comb begin
        w_full   = (r_wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                   (r_wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);
        w_count  = r_wptr - rptr;
        w_accept = i_wr & ~w_full;
        w_reject = i_wr & w_full;
    end

    // Write pointer advance and one-cycle acknowledge of accepted writes.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_wptr   <= '0;
            r_wr_ack <= 1'b0;
        end else begin
            r_wr_ack <= w_accept;
            if (w_accept) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
        end
    end

    // Overflow status: a rejected write beats a simultaneous clear, so the
    // clear-plus-reject cycle leaves exactly one recorded drop.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_reject) begin
            r_overflow <= 1'b1;
            if (ovf_clr) begin
                r_drop_cnt <= c_DROP_ONE;
            end else if (r_drop_cnt != c_DROP_MAX) begin
                r_drop_cnt <= r_drop_cnt + c_DROP_ONE;
            end
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

    assign fifo_wr          = w_accept;
    assign wptr             = r_wptr;
    assign fifo_full        = w_full;
    assign fifo_almost_full = (w_count >= c_AF);
    assign fifo_count       = w_count;
    assign wr_ack           = r_wr_ack;
    assign overflow         = r_overflow;
    assign drop_cnt         = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_write_pointer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_write_pointer_ctrl
// Description : Scoreboard bench for write_pointer_ctrl. The stimulus process
//               pushes the expected outputs of every cycle; a monitor pops
//               and compares them on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_write_pointer_ctrl;

    localparam int ADDR_WIDTH     = 3;
    localparam int AF_THRESH      = 6;
    localparam int DROP_CNT_WIDTH = 8;
    localparam int DEPTH          = 1 << ADDR_WIDTH;
    localparam int PMOD           = 2 * DEPTH;
    localparam int DMAX           = (1 << DROP_CNT_WIDTH) - 1;

    logic                      clk;
    logic                      rstn;
    logic                      i_wr;
    logic [ADDR_WIDTH:0]       rptr;
    logic                      ovf_clr;
    logic                      fifo_wr;
    logic [ADDR_WIDTH:0]       wptr;
    logic                      fifo_full;
    logic                      fifo_almost_full;
    logic [ADDR_WIDTH:0]       fifo_count;
    logic                      wr_ack;
    logic                      overflow;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt;

    write_pointer_ctrl #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .AF_THRESH     (AF_THRESH),
        .DROP_CNT_WIDTH(DROP_CNT_WIDTH)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .i_wr            (i_wr),
        .rptr            (rptr),
        .ovf_clr         (ovf_clr),
        .fifo_wr         (fifo_wr),
        .wptr            (wptr),
        .fifo_full       (fifo_full),
        .fifo_almost_full(fifo_almost_full),
        .fifo_count      (fifo_count),
        .wr_ack          (wr_ack),
        .overflow        (overflow),
        .drop_cnt        (drop_cnt)
    );

    typedef struct {
        int wptr;
        int count;
        int full;
        int af;
        int fwr;
        int ack;
        int ovf;
        int drop;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    // Reference model: total write/read positions modulo 2*DEPTH, and
    // occupancy by plain subtraction.
    int m_w    = 0;
    int m_r    = 0;
    int m_ack  = 0;
    int m_ovf  = 0;
    int m_drop = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every presented cycle against the scoreboard.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("wptr",       int'(wptr),             e.wptr);
            check("fifo_count", int'(fifo_count),       e.count);
            check("fifo_full",  int'(fifo_full),        e.full);
            check("almost_full",int'(fifo_almost_full), e.af);
            check("fifo_wr",    int'(fifo_wr),          e.fwr);
            check("wr_ack",     int'(wr_ack),           e.ack);
            check("overflow",   int'(overflow),         e.ovf);
            check("drop_cnt",   int'(drop_cnt),         e.drop);
        end
    end

    // One clock cycle: drive inputs, push expectations, advance the model.
    // Called just after a rising edge.
    task automatic cycle(input int wr, input int rd, input int clr);
        exp_t e;
        int   cnt;
        cnt     = ((m_w - m_r) % PMOD + PMOD) % PMOD;
        i_wr    = wr[0];
        ovf_clr = clr[0];
        rptr    = (ADDR_WIDTH+1)'(m_r);
        e.wptr  = m_w;
        e.count = cnt;
        e.full  = (cnt == DEPTH) ? 1 : 0;
        e.af    = (cnt >= AF_THRESH) ? 1 : 0;
        e.fwr   = (wr != 0 && cnt != DEPTH) ? 1 : 0;
        e.ack   = m_ack;
        e.ovf   = m_ovf;
        e.drop  = m_drop;
        exp_q.push_back(e);
        m_ack = e.fwr;
        if (e.fwr != 0) m_w = (m_w + 1) % PMOD;
        if (wr != 0 && e.full != 0) begin
            m_ovf  = 1;
            m_drop = (clr != 0) ? 1 : ((m_drop < DMAX) ? m_drop + 1 : DMAX);
        end else if (clr != 0) begin
            m_ovf  = 0;
            m_drop = 0;
        end
        if (rd != 0 && cnt > 0) m_r = (m_r + 1) % PMOD;
        @(posedge clk);
        #1;
    endtask

    function automatic int occ();
        return ((m_w - m_r) % PMOD + PMOD) % PMOD;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn    = 1'b1;
        i_wr    = 1'b0;
        ovf_clr = 1'b0;
        rptr    = '0;
        #2;
        check("rst_wptr",  int'(wptr),             0);
        check("rst_count", int'(fifo_count),       0);
        check("rst_full",  int'(fifo_full),        0);
        check("rst_af",    int'(fifo_almost_full), 0);
        check("rst_ack",   int'(wr_ack),           0);
        check("rst_ovf",   int'(overflow),         0);
        check("rst_drop",  int'(drop_cnt),         0);
        @(posedge clk);
        #1;
        rstn = 1'b0;

        // Fill from empty: eight accepted writes.
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0);
        // Held writes while full, then clear.
        for (int i = 0; i < 3; i++) cycle(1, 0, 0);
        cycle(0, 0, 1);
        // Read and write together while full: write rejected, then accepted.
        cycle(1, 1, 0);
        cycle(1, 0, 0);
        cycle(0, 0, 0);
        // Drain to two entries, then stream with reads tracking.
        for (int i = 0; i < 6; i++) cycle(0, 1, 0);
        for (int i = 0; i < 20; i++) cycle(1, 1, 0);
        // Fill, then drive the drop counter into saturation.
        while (occ() < DEPTH) cycle(1, 0, 0);
        for (int i = 0; i < 300; i++) cycle(1, 0, 0);
        cycle(1, 0, 1);
        cycle(0, 0, 0);
        // Drain, then write up to wptr=5 with overflow still set.
        for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0);
        for (int i = 0; i < PMOD && m_w != 5; i++) cycle(1, 1, 0);

        // Asynchronous reset mid-burst, observed before the next edge.
        i_wr = 1'b1;
        rptr = (ADDR_WIDTH+1)'(m_r);
        #1;
        rstn = 1'b1;
        #1;
        check("arst_wptr", int'(wptr),     0);
        check("arst_ack",  int'(wr_ack),   0);
        check("arst_ovf",  int'(overflow), 0);
        check("arst_drop", int'(drop_cnt), 0);
        i_wr = 1'b0;
        rptr = '0;
        m_w = 0; m_r = 0; m_ack = 0; m_ovf = 0; m_drop = 0;
        @(posedge clk);
        #1;
        check("arst_hold_wptr", int'(wptr), 0);
        rstn = 1'b0;
        cycle(1, 0, 0);
        cycle(0, 0, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cycle(int'($urandom_range(0, 3) != 0),
                  int'($urandom_range(0, 2) == 0),
                  int'($urandom_range(0, 15) == 0));
        end

        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/write_pointer_ctrl.md
Name: write_pointer_ctrl

Overview:
Write-side pointer controller for the synchronous FIFO. It is the counterpart of the read-pointer block.
- Gates the top-level write request against FIFO full.
- Advances the write pointer (wptr).
- Derives occupancy, full and almost-full from wptr versus the read pointer (rptr).
- Records write-overflow events for status/debug.
- Sits between the top-level write interface and the FIFO memory write port. The read-pointer block and the memory share wptr/rptr.

Parameters:
ADDR_WIDTH, 3, memory address bits; FIFO depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits (extra wrap bit).
AF_THRESH, 6, occupancy at or above which fifo_almost_full asserts; legal range 1..2**ADDR_WIDTH.
DROP_CNT_WIDTH, 8, width of the saturating rejected-write counter.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rstn  input  1  asynchronous, active-high reset (asserted = 1), acts on posedge rstn.
i_wr  input  1  write request from top module.
rptr  input  ADDR_WIDTH+1  current read pointer from the read-pointer block.
ovf_clr  input  1  synchronous clear of overflow and drop_cnt.
fifo_wr  output  1  qualified memory write enable, combinational = i_wr & !fifo_full.
wptr  output  ADDR_WIDTH+1  write pointer (register); memory address = wptr[ADDR_WIDTH-1:0].
fifo_full  output  1  combinational full flag.
fifo_almost_full  output  1  combinational, fifo_count >= AF_THRESH.
fifo_count  output  ADDR_WIDTH+1  occupancy, combinational, 0..2**ADDR_WIDTH.
wr_ack  output  1  registered; high for one cycle after each accepted write.
overflow  output  1  sticky; set by any rejected write.
drop_cnt  output  DROP_CNT_WIDTH  saturating count of rejected writes.

Behaviour:
- Reset (rstn=1, asynchronous, any time including mid-burst):
  - wptr=0, wr_ack=0, overflow=0, drop_cnt=0.
  - With rptr also 0: fifo_count=0, fifo_full=0, fifo_almost_full=0 (unless AF_THRESH=0, which is illegal).
  - Registers hold reset values while rstn=1; normal operation resumes on the first rising clk edge after deassertion.
- Full: fifo_full = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) && (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]).
- Empty is not produced here; it is owned by the read side.
- fifo_count = (wptr - rptr) modulo 2**(ADDR_WIDTH+1). It is correct across pointer wrap.
- Write accept: fifo_wr=1 when i_wr=1 and fifo_full=0. On that clock edge wptr <= wptr+1, wrapping naturally from all-ones to 0 (wrap bit toggles every depth writes).
- Not accepted: wptr holds.
- Latency:
  - fifo_wr is zero-latency (same cycle as i_wr).
  - wptr, fifo_count and flags reflect the write one cycle later.
  - wr_ack rises the cycle after acceptance. Back-to-back accepts hold wr_ack high continuously.
- Simultaneous read while full: full is evaluated on current pointers, so a write in the same cycle as a read is still rejected (no write-through). The write is accepted on the next cycle once rptr has advanced.
- Simultaneous read and write while not full: both pointers advance; fifo_count is unchanged next cycle.
- Rejected write (i_wr=1 and fifo_full=1):
  - overflow <= 1.
  - drop_cnt <= drop_cnt+1, saturating at all-ones (no wrap).
- ovf_clr=1: overflow <= 0 and drop_cnt <= 0. If a rejected write occurs in the same cycle, set wins: overflow=1, drop_cnt=1.
- i_wr is ignored for all state except drop/overflow when full; there are no X-propagation requirements beyond standard 0/1 inputs.

Test Plan:
(ADDR_WIDTH=3, AF_THRESH=6, DROP_CNT_WIDTH=8)
1. Reset, then 8 consecutive writes, rptr held 0 -> wptr steps 1..8 (4'b1000); fifo_almost_full rises after 6th write; fifo_full=1 after 8th; wr_ack high 8 cycles; overflow=0.
2. Full, i_wr held 3 more cycles -> fifo_wr=0, wptr stays 8, overflow=1, drop_cnt=3; then ovf_clr pulse -> overflow=0, drop_cnt=0.
3. Full, same cycle rptr advances 0->1 with i_wr=1 -> write rejected (drop_cnt+1); next cycle write accepted, wptr=9, fifo_count=8.
4. Wrap: stream 20 writes with rptr tracking wptr-2 -> wptr wraps 15->0; fifo_count stays 2; full never asserts.
5. Overflow with drop_cnt forced near max: 300 rejected writes -> drop_cnt saturates at 255. Then ovf_clr together with a rejected write -> overflow=1, drop_cnt=1.
6. Assert rstn asynchronously mid-burst with wptr=5 -> wptr, wr_ack, overflow, drop_cnt go to 0 immediately (before the next clk edge); the first write after deassertion gives wptr=1.
